out_channel_reader: RTL and testbench

// - Host-side drain for the program out channel: captures each word the executing program emits
//   (out instruction) into a circular buffer and presents it to the host over valid/ready.
// - Sits between the instruction engine's out port and the host/test checker.
// - Replaces direct peeking at the out-channel memory; preserves emission order exactly.

---
 rtl/out_channel_pkg.sv | 16 +
 rtl/out_channel_ram.sv | 23 ++
 rtl/out_channel_reader.sv | 98 +++++++++
 tb/tb_out_channel_reader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/out_channel_pkg.sv
// Shared types and helpers for the program out-channel drain.
package out_channel_pkg;

  localparam int DefaultWidth = 12;
  localparam int DefaultNOut  = 2000;

  typedef logic [DefaultWidth-1:0] word_t;

  typedef enum logic {EMPTY, HOLD} out_state_t;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/out_channel_ram.sv
// Simple dual-port storage for the out channel: one write port, one asynchronous read port.
module out_channel_ram #(
  parameter int Width     = 12,
  parameter int Depth     = 2000,
  parameter int AddrWidth = 11
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_channel_reader.sv
// Circular buffer capturing program out words and presenting them to the host over valid/ready.
module out_channel_reader
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultWidth,
  parameter int NOut               = DefaultNOut,
  parameter int PtrWidth           = 11,
  parameter int CountWidth         = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [MemoryElementWidth-1:0] wr_data,
  input  logic                          flush,
  output logic                          rd_valid,
  output logic [MemoryElementWidth-1:0] rd_data,
  input  logic                          rd_ready,
  output logic [PtrWidth:0]             count,
  output logic                          overflow,
  output logic [CountWidth-1:0]         total_written,
  output logic [CountWidth-1:0]         dropped
);

  if ((2 ** PtrWidth) < NOut || NOut < 2) begin : g_bad_params
    $error("out_channel_reader: PtrWidth too small for NOut, or NOut < 2");
  end

  localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(NOut);

  out_state_t state;
  logic [PtrWidth-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [MemoryElementWidth-1:0] ram_rdata;
  logic load, drop;

  out_channel_ram #(
    .Width     (MemoryElementWidth),
    .Depth     (NOut),
    .AddrWidth (PtrWidth)
  ) u_ram (
    .clock (clock),
    .we    (wr_valid && !flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // A load frees a slot, so a full buffer only drops when nothing is loaded this cycle.
  always_comb begin
    load        = (count != '0) && ((state == EMPTY) || rd_ready);
    drop        = wr_valid && (count == FullCount) && !load;
    wr_ptr_next = PtrWidth'(ptr_inc(32'(wr_ptr), NOut));
    rd_ptr_next = PtrWidth'(ptr_inc(32'(rd_ptr), NOut));
  end

  assign rd_valid = (state == HOLD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= EMPTY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_data       <= '0;
      overflow      <= 1'b0;
      total_written <= '0;
      dropped       <= '0;
    end else if (flush) begin
      state         <= EMPTY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_data       <= '0;
      overflow      <= 1'b0;
      total_written <= '0;
      dropped       <= '0;
    end else begin
      if (wr_valid) begin
        wr_ptr        <= wr_ptr_next;
        total_written <= total_written + CountWidth'(1);
      end
      if (load || drop) rd_ptr <= rd_ptr_next;
      if (load) rd_data <= ram_rdata;

      if (wr_valid && !load && !drop) count <= count + (PtrWidth + 1)'(1);
      else if (load && !wr_valid)     count <= count - (PtrWidth + 1)'(1);

      if (drop) begin
        overflow <= 1'b1;
        if (dropped != '1) dropped <= dropped + CountWidth'(1);
      end

      if (load)                              state <= HOLD;
      else if ((state == HOLD) && rd_ready)  state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_out_channel_reader.sv
// Scoreboard bench: stimulus pushes expected out words, a monitor pops them on each handshake.
module tb_out_channel_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_valid, flush, rd_ready;
  logic [11:0] wr_data;
  logic        rd_valid, overflow;
  logic [11:0] rd_data;
  logic [2:0]  count;
  logic [31:0] total_written, dropped;

  logic        b_wr_valid, b_flush, b_rd_ready;
  logic [11:0] b_wr_data;
  logic        b_rd_valid, b_overflow;
  logic [11:0] b_rd_data;
  logic [1:0]  b_count;
  logic [31:0] b_total_written, b_dropped;

  int vectors     = 0;
  int miscompares = 0;
  logic [11:0] exp_q [$];

  always #5 clock = ~clock;

  out_channel_reader #(.MemoryElementWidth(12), .NOut(4), .PtrWidth(2), .CountWidth(32)) u_dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data), .flush(flush),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .count(count),
    .overflow(overflow), .total_written(total_written), .dropped(dropped)
  );

  out_channel_reader #(.MemoryElementWidth(12), .NOut(2), .PtrWidth(1), .CountWidth(32)) u_dut2 (
    .clock(clock), .reset(reset), .wr_valid(b_wr_valid), .wr_data(b_wr_data), .flush(b_flush),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_ready(b_rd_ready), .count(b_count),
    .overflow(b_overflow), .total_written(b_total_written), .dropped(b_dropped)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [11:0] data, input bit expect_out);
    wr_valid = 1'b1;
    wr_data  = data;
    if (expect_out) exp_q.push_back(data);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0 && !rd_valid) break;
      step();
    end
    check_output(name, {31'd0, (exp_q.size() == 0 && !rd_valid)}, 32'd1);
  endtask

  // The handshake completes at the next rising edge, so rd_data is checked mid-cycle.
  always @(negedge clock) begin
    if (!reset && !flush && rd_valid && rd_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_word: got %0d, expected no word", rd_data);
      end else begin
        logic [11:0] exp_word;
        exp_word = exp_q.pop_front();
        if (rd_data !== exp_word) begin
          miscompares++;
          $display("[TB] FAIL read_word: got %0d, expected %0d", rd_data, exp_word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; flush = 1'b0; rd_ready = 1'b0;
    b_wr_valid = 1'b0; b_wr_data = '0; b_flush = 1'b0; b_rd_ready = 1'b0;
    repeat (2) step();
    check_output("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_output("reset_count", {29'd0, count}, 32'd0);
    check_output("reset_total", total_written, 32'd0);
    check_output("reset_rd_data", {20'd0, rd_data}, 32'd0);
    reset = 1'b0;
    step();

    $display("[TB] emission order");
    rd_ready = 1'b1;
    apply_stimulus(12'd2, 1'b1);
    apply_stimulus(12'd1, 1'b1);
    wait_drain("order_drain");
    check_output("order_total", total_written, 32'd2);
    check_output("order_rd_valid", {31'd0, rd_valid}, 32'd0);

    $display("[TB] back-pressure then full plus load");
    rd_ready = 1'b0;
    for (int i = 10; i <= 14; i++) apply_stimulus(12'(i), 1'b1);
    check_output("bp_rd_valid", {31'd0, rd_valid}, 32'd1);
    check_output("bp_rd_data", {20'd0, rd_data}, 32'd10);
    check_output("bp_count", {29'd0, count}, 32'd4);
    step(); step();
    check_output("bp_rd_data_stable", {20'd0, rd_data}, 32'd10);
    rd_ready = 1'b1;
    apply_stimulus(12'd15, 1'b1);
    check_output("fullload_count", {29'd0, count}, 32'd4);
    check_output("fullload_dropped", dropped, 32'd0);
    check_output("fullload_overflow", {31'd0, overflow}, 32'd0);
    wait_drain("bp_drain");
    check_output("bp_total", total_written, 32'd8);

    $display("[TB] pointer wrap streaming");
    for (int i = 20; i <= 29; i++) apply_stimulus(12'(i), 1'b1);
    wait_drain("wrap_drain");
    check_output("wrap_overflow", {31'd0, overflow}, 32'd0);
    check_output("wrap_dropped", dropped, 32'd0);
    check_output("wrap_total", total_written, 32'd18);

    $display("[TB] overflow drops oldest RAM word");
    rd_ready = 1'b0;
    apply_stimulus(12'd1, 1'b1);
    apply_stimulus(12'd2, 1'b0);
    for (int i = 3; i <= 6; i++) apply_stimulus(12'(i), 1'b1);
    check_output("ovf_count", {29'd0, count}, 32'd4);
    check_output("ovf_flag", {31'd0, overflow}, 32'd1);
    check_output("ovf_dropped", dropped, 32'd1);
    check_output("ovf_rd_data", {20'd0, rd_data}, 32'd1);
    rd_ready = 1'b1;
    wait_drain("ovf_drain");
    check_output("ovf_sticky", {31'd0, overflow}, 32'd1);

    $display("[TB] flush beats simultaneous write");
    rd_ready = 1'b0;
    for (int i = 7; i <= 9; i++) apply_stimulus(12'(i), 1'b0);
    flush = 1'b1; wr_valid = 1'b1; wr_data = 12'd99;
    step();
    flush = 1'b0; wr_valid = 1'b0;
    check_output("flush_count", {29'd0, count}, 32'd0);
    check_output("flush_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_output("flush_total", total_written, 32'd0);
    check_output("flush_overflow", {31'd0, overflow}, 32'd0);
    check_output("flush_dropped", dropped, 32'd0);
    step(); step();
    check_output("flush_stays_empty", {31'd0, rd_valid}, 32'd0);

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 40; i <= 42; i++) apply_stimulus(12'(i), 1'b0);
    #2 reset = 1'b1;
    #1;
    check_output("areset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check_output("areset_count", {29'd0, count}, 32'd0);
    check_output("areset_total", total_written, 32'd0);
    check_output("areset_rd_data", {20'd0, rd_data}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    rd_ready = 1'b1;
    apply_stimulus(12'd50, 1'b1);
    wait_drain("post_reset_drain");
    check_output("post_reset_total", total_written, 32'd1);

    $display("[TB] depth-2 full corner");
    b_rd_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      b_wr_valid = 1'b1; b_wr_data = 12'(i);
      step();
    end
    check_output("d2_full_count", {30'd0, b_count}, 32'd2);
    check_output("d2_rd_data", {20'd0, b_rd_data}, 32'd1);
    b_wr_data = 12'd4; b_rd_ready = 1'b1;
    step();
    b_wr_valid = 1'b0; b_rd_ready = 1'b0;
    check_output("d2_load_count", {30'd0, b_count}, 32'd2);
    check_output("d2_load_dropped", b_dropped, 32'd0);
    check_output("d2_load_rd_data", {20'd0, b_rd_data}, 32'd2);
    b_wr_valid = 1'b1; b_wr_data = 12'd5;
    step();
    b_wr_valid = 1'b0;
    check_output("d2_drop_dropped", b_dropped, 32'd1);
    check_output("d2_drop_overflow", {31'd0, b_overflow}, 32'd1);
    check_output("d2_drop_rd_data", {20'd0, b_rd_data}, 32'd2);
    check_output("d2_total", b_total_written, 32'd5);

    check_output("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
